// File: rtl/branch_prediction_tracker_if.sv
// IF-side capture, MEM-side resolution and head/flush signals of the tracker.
interface branch_prediction_tracker_if;
  // IF side: fetch metadata
  logic        if_push;
  logic [31:0] if_pc;
  logic [31:0] if_predicted_pc;
  logic [1:0]  if_pred;
  logic        if_btb_hit;
  // MEM side: resolution of the oldest entry
  logic        mem_pop;
  logic        mem_is_branch;
  logic        mem_actual_taken;
  logic [31:0] mem_actual_target;
  // head entry, predictor write-back and redirect
  logic [31:0] mem_pc;
  logic [31:0] mem_predicted_pc;
  logic [1:0]  mem_pred;
  logic        mem_btb_hit;
  logic [1:0]  updated_prediction;
  logic        misprediction;
  logic        flush;
  logic [31:0] redirect_pc;

  modport master (
    output if_push, if_pc, if_predicted_pc, if_pred, if_btb_hit,
    output mem_pop, mem_is_branch, mem_actual_taken, mem_actual_target,
    input  mem_pc, mem_predicted_pc, mem_pred, mem_btb_hit,
    input  updated_prediction, misprediction, flush, redirect_pc
  );

  modport slave (
    input  if_push, if_pc, if_predicted_pc, if_pred, if_btb_hit,
    input  mem_pop, mem_is_branch, mem_actual_taken, mem_actual_target,
    output mem_pc, mem_predicted_pc, mem_pred, mem_btb_hit,
    output updated_prediction, misprediction, flush, redirect_pc
  );
endinterface

// File: rtl/branch_prediction_tracker.sv
// In-flight branch prediction FIFO: IF pushes metadata, MEM resolves the head,
// mispredicts flush the whole queue and redirect fetch one cycle later.
module branch_prediction_tracker #(
  parameter int depth     = 4,
  parameter int cnt_width = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  branch_prediction_tracker_if.slave  bus,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(depth):0]      occupancy,
  output logic                        overflow,
  output logic [cnt_width-1:0]        branch_count,
  output logic [cnt_width-1:0]        mispredict_count
);
  localparam int PTR_W = $clog2(depth);
  localparam logic [PTR_W:0] FULL_OCC = (PTR_W+1)'(depth);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ppc;
    logic [1:0]  pred;
    logic        btb_hit;
  } entry_t;

  entry_t            ent_q [depth];
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    occ;
  entry_t            h;
  logic              pop_ok, push_ok, wr_en, mis_raw, mis_pop;
  logic [1:0]        upd_raw;
  logic [31:0]       redir;
  logic              flush_q;
  logic [31:0]       redirect_q;

  assign full    = (occ == FULL_OCC);
  assign empty   = (occ == '0);
  assign occupancy = occ;
  assign pop_ok  = bus.mem_pop && !empty;
  // a pop frees a slot in the same cycle, so a full FIFO can still accept
  assign push_ok = bus.if_push && !flush_q && (!full || pop_ok);
  assign mis_pop = pop_ok && mis_raw;
  // a mispredict wipes the queue, so a same-cycle push must not land
  assign wr_en   = push_ok && !mis_pop;

  // head view; zeros when empty so downstream never sees stale entries
  always_comb begin
    h = '0;
    if (!empty) h = ent_q[head];
  end

  // resolve the head entry against the actual outcome
  always_comb begin
    mis_raw = 1'b0;
    upd_raw = 2'b00;
    redir   = h.pc + 32'd4;
    if (bus.mem_is_branch) begin
      if (bus.mem_actual_taken) redir = bus.mem_actual_target;
      if (h.btb_hit) begin
        mis_raw = (h.pred[1] != bus.mem_actual_taken) ||
                  (h.pred[1] && bus.mem_actual_taken && (h.ppc != bus.mem_actual_target));
        if (bus.mem_actual_taken)
          upd_raw = (h.pred == 2'b11) ? 2'b11 : h.pred + 2'b01;
        else
          upd_raw = (h.pred == 2'b00) ? 2'b00 : h.pred - 2'b01;
      end else begin
        mis_raw = bus.mem_actual_taken;
        upd_raw = bus.mem_actual_taken ? 2'b10 : 2'b01;
      end
    end else begin
      mis_raw = h.btb_hit && h.pred[1];
    end
  end

  assign bus.mem_pc             = h.pc;
  assign bus.mem_predicted_pc   = h.ppc;
  assign bus.mem_pred           = h.pred;
  assign bus.mem_btb_hit        = h.btb_hit;
  assign bus.misprediction      = mis_pop;
  assign bus.updated_prediction = empty ? 2'b00 : upd_raw;
  assign bus.flush              = flush_q;
  assign bus.redirect_pc        = redirect_q;

  // entry storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) ent_q[tail] <= '{pc: bus.if_pc, ppc: bus.if_predicted_pc,
                                pred: bus.if_pred, btb_hit: bus.if_btb_hit};
  end

  // pointers and occupancy; a mispredict resets them to an empty queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (mis_pop) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (pop_ok) head <= head + PTR_W'(1);
      if (wr_en)  tail <= tail + PTR_W'(1);
      case ({wr_en, pop_ok})
        2'b10:   occ <= occ + (PTR_W+1)'(1);
        2'b01:   occ <= occ - (PTR_W+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // one-cycle flush with the corrected fetch PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      flush_q <= mis_pop;
      if (mis_pop) redirect_q <= redir;
    end
  end

  // sticky record of a push dropped because the queue was full
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                       overflow <= 1'b0;
    else if (bus.if_push && !flush_q && full && !pop_ok) overflow <= 1'b1;
  end

  // saturating performance counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (pop_ok && bus.mem_is_branch && !(&branch_count))
        branch_count <= branch_count + cnt_width'(1);
      if (mis_pop && !(&mispredict_count))
        mispredict_count <= mispredict_count + cnt_width'(1);
    end
  end
endmodule

// File: tb/tb_branch_prediction_tracker.sv
// Randomized + directed bench for branch_prediction_tracker with a queue-based
// reference model checked every cycle on the falling edge.
module tb_branch_prediction_tracker;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int SAT   = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_prediction_tracker_if b();
  logic          full, empty, overflow;
  logic [2:0]    occupancy;
  logic [CW-1:0] branch_count, mispredict_count;

  branch_prediction_tracker #(.depth(DEPTH), .cnt_width(CW)) dut (
    .clk(clk), .rst(rst), .bus(b.slave),
    .full(full), .empty(empty), .occupancy(occupancy), .overflow(overflow),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ppc;
    logic [1:0]  pred;
    logic        hit;
  } ent_t;

  ent_t        q[$];
  bit          m_flush, m_ovf;
  logic [31:0] m_redir;
  int          m_bc, m_mc;

  always @(negedge clk) begin : cmp
    ent_t        h;
    bit          is_e, pop, mis, push_ok;
    logic [1:0]  up;
    logic [31:0] rd;
    if (!rst) begin
      q.delete();
      m_flush = 0; m_ovf = 0; m_redir = '0; m_bc = 0; m_mc = 0;
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_occ", occupancy, 0);
      chk("rst_flush", b.flush, 0);
      chk("rst_redirect", b.redirect_pc, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_bc", branch_count, 0);
      chk("rst_mc", mispredict_count, 0);
    end else begin
      is_e = (q.size() == 0);
      pop  = b.mem_pop && !is_e;
      h    = '{default: '0};
      if (!is_e) h = q[0];
      mis = 0; up = 2'b00; rd = h.pc + 32'd4;
      if (b.mem_is_branch) begin
        if (b.mem_actual_taken) rd = b.mem_actual_target;
        if (h.hit) begin
          mis = (h.pred[1] != b.mem_actual_taken) ||
                (h.pred[1] && b.mem_actual_taken && h.ppc != b.mem_actual_target);
          if (b.mem_actual_taken) up = (h.pred == 2'd3) ? 2'd3 : 2'(h.pred + 2'd1);
          else                    up = (h.pred == 2'd0) ? 2'd0 : 2'(h.pred - 2'd1);
        end else begin
          mis = b.mem_actual_taken;
          up  = b.mem_actual_taken ? 2'd2 : 2'd1;
        end
      end else begin
        mis = h.hit && h.pred[1];
      end
      mis = mis && pop;

      chk("occupancy", occupancy, q.size());
      chk("full", full, q.size() == DEPTH);
      chk("empty", empty, is_e);
      chk("overflow", overflow, m_ovf);
      chk("flush", b.flush, m_flush);
      if (m_flush) chk("redirect_pc", b.redirect_pc, m_redir);
      chk("branch_count", branch_count, m_bc);
      chk("mispredict_count", mispredict_count, m_mc);
      chk("mem_pc", b.mem_pc, h.pc);
      chk("mem_predicted_pc", b.mem_predicted_pc, h.ppc);
      chk("mem_pred", b.mem_pred, h.pred);
      chk("mem_btb_hit", b.mem_btb_hit, h.hit);
      chk("misprediction", b.misprediction, mis);
      if (is_e)     chk("updated_prediction_empty", b.updated_prediction, 0);
      else if (pop) chk("updated_prediction", b.updated_prediction, up);

      // advance the model to the state after the coming rising edge
      push_ok = b.if_push && !m_flush && (q.size() < DEPTH || pop);
      if (b.if_push && !m_flush && q.size() == DEPTH && !pop) m_ovf = 1;
      if (pop && b.mem_is_branch && m_bc < SAT) m_bc++;
      m_flush = mis;
      if (mis) begin
        if (m_mc < SAT) m_mc++;
        m_redir = rd;
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push_ok) q.push_back('{pc: b.if_pc, ppc: b.if_predicted_pc,
                                   pred: b.if_pred, hit: b.if_btb_hit});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_in(input bit push, input logic [31:0] pc, input logic [31:0] ppc,
                        input logic [1:0] pred, input bit hit, input bit pop,
                        input bit br, input bit tk, input logic [31:0] tgt);
    b.if_push = push; b.if_pc = pc; b.if_predicted_pc = ppc;
    b.if_pred = pred; b.if_btb_hit = hit;
    b.mem_pop = pop; b.mem_is_branch = br; b.mem_actual_taken = tk;
    b.mem_actual_target = tgt;
  endtask

  task automatic idle();
    set_in(0, '0, '0, 2'b00, 0, 0, 0, 0, '0);
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("lit_reset_empty", empty, 1);

    // fill to full, then overflow, then pop returns the oldest pc
    for (int i = 0; i < 4; i++) begin
      set_in(1, 32'h10 + 32'(4*i), '0, 2'b00, 0, 0, 0, 0, '0);
      nxt();
    end
    idle();
    chk("lit_full", full, 1);
    chk("lit_occ4", occupancy, 4);
    set_in(1, 32'h50, '0, 2'b00, 0, 0, 0, 0, '0);
    nxt();
    idle();
    chk("lit_overflow", overflow, 1);
    chk("lit_occ_still4", occupancy, 4);
    set_in(0, '0, '0, 2'b00, 0, 1, 0, 0, '0);
    @(negedge clk);
    chk("lit_first_pc", b.mem_pc, 32'h10);
    nxt();
    for (int i = 0; i < 3; i++) nxt();
    idle();
    chk("lit_drained", empty, 1);

    // correctly predicted taken branch
    set_in(1, 32'h100, 32'h200, 2'b11, 1, 0, 0, 0, '0);
    nxt();
    set_in(0, '0, '0, 2'b00, 0, 1, 1, 1, 32'h200);
    @(negedge clk);
    chk("lit_hit_mis", b.misprediction, 0);
    chk("lit_hit_upd", b.updated_prediction, 2'b11);
    nxt();
    idle();
    chk("lit_bc1", branch_count, 1);

    // predicted taken, actually not taken
    set_in(1, 32'h100, 32'h200, 2'b10, 1, 0, 0, 0, '0);
    nxt();
    set_in(0, '0, '0, 2'b00, 0, 1, 1, 0, '0);
    @(negedge clk);
    chk("lit_nt_mis", b.misprediction, 1);
    chk("lit_nt_upd", b.updated_prediction, 2'b01);
    nxt();
    idle();
    chk("lit_nt_flush", b.flush, 1);
    chk("lit_nt_redirect", b.redirect_pc, 32'h104);
    nxt();
    chk("lit_flush_one_cycle", b.flush, 0);

    // mispredict clears queue and same-cycle push; flush-cycle push ignored
    for (int i = 0; i < 3; i++) begin
      set_in(1, 32'h10 + 32'(4*i), '0, 2'b00, 0, 0, 0, 0, '0);
      nxt();
    end
    set_in(1, 32'h1c, '0, 2'b00, 0, 1, 1, 1, 32'h400);
    nxt();
    set_in(1, 32'h20, '0, 2'b00, 0, 0, 0, 0, '0);
    chk("lit_clr_flush", b.flush, 1);
    chk("lit_clr_redirect", b.redirect_pc, 32'h400);
    chk("lit_clr_empty", empty, 1);
    nxt();
    idle();
    chk("lit_flush_push_ignored", occupancy, 0);

    // non-branch with predicted-taken BTB hit, pc+4 wraps
    set_in(1, 32'hFFFF_FFFC, 32'h0, 2'b10, 1, 0, 0, 0, '0);
    nxt();
    set_in(0, '0, '0, 2'b00, 0, 1, 0, 0, '0);
    @(negedge clk);
    chk("lit_nb_mis", b.misprediction, 1);
    nxt();
    idle();
    chk("lit_wrap_redirect", b.redirect_pc, 32'h0);
    nxt();

    // pointer wrap: 3*depth push/pop pairs in order
    for (int i = 0; i < 3*DEPTH; i++) begin
      set_in(1, 32'h1000 + 32'(4*i), '0, 2'b00, 0, i > 0, 0, 0, '0);
      if (i > 0) begin
        @(negedge clk);
        chk("lit_wrap_order", b.mem_pc, 32'h1000 + 32'(4*(i-1)));
      end
      nxt();
    end
    set_in(0, '0, '0, 2'b00, 0, 1, 0, 0, '0);
    @(negedge clk);
    chk("lit_wrap_last", b.mem_pc, 32'h1000 + 32'(4*(3*DEPTH-1)));
    nxt();
    idle();

    // counter saturation
    for (int i = 0; i < 17; i++) begin
      set_in(1, 32'h2000 + 32'(4*i), '0, 2'b00, 0, 0, 0, 0, '0);
      nxt();
      set_in(0, '0, '0, 2'b00, 0, 1, 1, 1, 32'h800);
      nxt();
      idle();
      nxt();
    end
    chk("lit_mc_sat", mispredict_count, 4'hF);
    chk("lit_bc_sat", branch_count, 4'hF);

    // randomized traffic with a mid-run asynchronous reset
    for (int i = 0; i < 3000; i++) begin
      set_in($urandom_range(0, 9) < 7, $urandom & 32'hFFFF_FFFC,
             ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300,
             2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
             $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0,
             $urandom_range(0, 1) != 0,
             ($urandom_range(0, 1) != 0) ? 32'h200 : 32'h300);
      if (i == 1500) begin
        #2 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
      end else begin
        nxt();
      end
    end
    idle();
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
